ins_fetch: RTL

INS_FETCH -- requirements
Module: ins_fetch

---
 rtl/ins_fetch_if.sv | 22 ++
 rtl/ins_fetch.sv | 101 ++++++++++
 2 files changed

// File: rtl/ins_fetch_if.sv
// ins_fetch_if: fetch-unit bus bundle covering the memory port, redirect input and decoder issue port.
interface ins_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        pc_bc_flag;
    logic [31:0] pc_bc;
    logic        if_stall;
    logic [31:0] ins;
    logic        ins_flag;
    logic [31:0] ins_imm;
    logic [31:0] pc;
    modport master (
        output mem_req, mem_addr, ins, ins_flag, ins_imm, pc,
        input  mem_done, mem_data, pc_bc_flag, pc_bc, if_stall
    );
    modport slave (
        input  mem_req, mem_addr, ins, ins_flag, ins_imm, pc,
        output mem_done, mem_data, pc_bc_flag, pc_bc, if_stall
    );
endinterface

// File: rtl/ins_fetch.sv
// ins_fetch: single-outstanding instruction fetcher with redirect/flush and a decoded-immediate issue queue.
module ins_fetch #(
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic         clk,
    input logic         rst,
    input logic         rdy,
    ins_fetch_if.master bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(QDEPTH);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2;
    logic [1:0]    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   pc_q  [QDEPTH];
    logic [31:0]   ins_q [QDEPTH];
    logic [31:0]   imm_q [QDEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic [31:0]   w, imm;
    logic [6:0]    op;
    logic [2:0]    f3;
    logic          push, pop, flush, shamt;
    assign w     = bus.mem_data;
    assign op    = w[6:0];
    assign f3    = w[14:12];
    assign shamt = op == 7'b0010011 && (f3 == 3'b001 || f3 == 3'b101);
    assign imm   = shamt ? {27'b0, w[24:20]} :
                   (op == 7'b0000011 || op == 7'b1100111 || op == 7'b0010011) ? {{20{w[31]}}, w[31:20]} :
                   op == 7'b0100011 ? {{20{w[31]}}, w[31:25], w[11:7]} :
                   op == 7'b1100011 ? {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0} :
                   (op == 7'b0110111 || op == 7'b0010111) ? {w[31:12], 12'b0} :
                   op == 7'b1101111 ? {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0} : 32'h0;
    assign flush = rdy & bus.pc_bc_flag;
    assign push  = rdy & ~bus.pc_bc_flag & (state == WAIT) & bus.mem_done;
    assign pop   = rdy & ~bus.pc_bc_flag & (count != '0) & ~bus.if_stall;
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wptr]  <= fetch_pc;
            ins_q[wptr] <= w;
            imm_q[wptr] <= imm;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
            bus.ins      <= '0;
            bus.ins_flag <= 1'b0;
            bus.ins_imm  <= '0;
            bus.pc       <= '0;
        end else if (!rdy) begin
            bus.ins_flag <= 1'b0;
        end else begin
            bus.ins_flag <= pop;
            if (pop) begin
                bus.ins     <= ins_q[rptr];
                bus.ins_imm <= imm_q[rptr];
                bus.pc      <= pc_q[rptr];
            end
            if (flush) begin
                wptr     <= '0;
                rptr     <= '0;
                count    <= '0;
                fetch_pc <= bus.pc_bc;
            end else begin
                if (push) begin
                    wptr     <= wptr + 1'b1;
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (pop) rptr <= rptr + 1'b1;
                count <= (push && !pop) ? count + 1'b1 : (!push && pop) ? count - 1'b1 : count;
            end
            // a redirect during an outstanding request must still absorb its mem_done
            case (state)
                IDLE: if (!bus.pc_bc_flag && count != FULL) begin
                    state        <= WAIT;
                    bus.mem_req  <= 1'b1;
                    bus.mem_addr <= fetch_pc;
                end
                WAIT: if (bus.mem_done) begin
                    state       <= IDLE;
                    bus.mem_req <= 1'b0;
                end else if (bus.pc_bc_flag) begin
                    state <= DROP;
                end
                DROP: if (bus.mem_done) begin
                    state       <= IDLE;
                    bus.mem_req <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
